// File: rtl/keypad_pkg.sv
// Shared width and event-encoding helpers for the keypad scanner and its event queue.
package keypad_pkg;

  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int code_width(input int rows, input int cols);
    return min1_clog2(rows * cols);
  endfunction

  // Event word: {release flag, key code}; the flag sits just above the code.
  function automatic int release_bit(input int rows, input int cols);
    return code_width(rows, cols);
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int evt_code(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// First-word-fall-through event queue with occupancy count and sticky overflow.
module key_evt_fifo
  import keypad_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  input  logic                          ovf_clr,
  output logic [WIDTH-1:0]              head,
  output logic                          valid,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          overflow
);
  localparam int AW = min1_clog2(DEPTH);
  localparam int NW = count_width(DEPTH);
  localparam logic [NW-1:0] FULL_CNT = NW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr, rd_next;
  logic             full, do_pop, do_push, drop;

  assign valid   = (count != '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign rd_next = rd_ptr + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      head     <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_next;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // head is registered so it holds its last value once the queue drains
      if (do_pop) begin
        if (count > NW'(1)) head <= mem[rd_next];
        else if (do_push)   head <= push_data;
      end else if (!valid && do_push) begin
        head <= push_data;
      end
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad front end: one-hot column scan, row synchroniser, per-key debounce,
// and an emitter that queues press (and optionally release) events.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int REPORT_RELEASE = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  output logic [COLS-1:0]                    col,
  input  logic [ROWS-1:0]                    fila,
  output logic [code_width(ROWS, COLS):0]    key_evt,
  output logic                               key_valid,
  input  logic                               key_ready,
  output logic [count_width(FIFO_DEPTH)-1:0] evt_count,
  output logic                               overflow,
  input  logic                               ovf_clr
);
  localparam int CW          = code_width(ROWS, COLS);
  localparam int RELEASE_BIT = release_bit(ROWS, COLS);
  localparam int SW          = min1_clog2(SCAN_DIV);
  localparam int CIW         = min1_clog2(COLS);
  localparam int RIW         = min1_clog2(ROWS);
  localparam int DW          = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0]  SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CIW-1:0] COL_LAST  = CIW'(COLS - 1);
  localparam logic [RIW-1:0] ROW_LAST  = RIW'(ROWS - 1);
  localparam logic [DW-1:0]  DB_LAST   = DW'(DEBOUNCE_SCANS - 1);

  logic [SW-1:0]   slot_cnt;
  logic [CIW-1:0]  col_idx;
  logic [ROWS-1:0] fila_meta, fila_sync;
  logic [COLS-1:0] stable  [ROWS];
  logic [COLS-1:0] pending [ROWS];
  logic [DW-1:0]   db_cnt  [ROWS][COLS];
  logic            emit_active;
  logic [RIW-1:0]  emit_row;
  logic [CIW-1:0]  emit_col;
  logic            sample_pt, push;
  logic [CW:0]     push_evt;

  assign sample_pt = (slot_cnt == SLOT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      col_idx  <= '0;
      col      <= COLS'(1);
    end else if (sample_pt) begin
      slot_cnt <= '0;
      col      <= {col[COLS-2:0], col[COLS-1]};
      col_idx  <= (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fila_meta <= '0;
      fila_sync <= '0;
    end else begin
      fila_meta <= fila;
      fila_sync <= fila_meta;
    end
  end

  // The emitter finishes ROWS cycles after a sample point, well before the next
  // one (SCAN_DIV >= ROWS+3), so its flag clear never meets a flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        stable[r]  <= '0;
        pending[r] <= '0;
        for (int c = 0; c < COLS; c++) db_cnt[r][c] <= '0;
      end
    end else begin
      if (emit_active) pending[emit_row][emit_col] <= 1'b0;
      if (sample_pt) begin
        for (int r = 0; r < ROWS; r++) begin
          if (fila_sync[r] == stable[r][col_idx]) begin
            db_cnt[r][col_idx] <= '0;
          end else if (db_cnt[r][col_idx] == DB_LAST) begin
            stable[r][col_idx]  <= ~stable[r][col_idx];
            db_cnt[r][col_idx]  <= '0;
            pending[r][col_idx] <= 1'b1;
          end else begin
            db_cnt[r][col_idx] <= db_cnt[r][col_idx] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      emit_active <= 1'b0;
      emit_row    <= '0;
      emit_col    <= '0;
    end else if (sample_pt) begin
      emit_active <= 1'b1;
      emit_row    <= '0;
      emit_col    <= col_idx;
    end else if (emit_active) begin
      emit_row <= emit_row + 1'b1;
      if (emit_row == ROW_LAST) emit_active <= 1'b0;
    end
  end

  always_comb begin
    push_evt = '0;
    push = emit_active && pending[emit_row][emit_col] &&
           ((REPORT_RELEASE != 0) || stable[emit_row][emit_col]);
    push_evt[RELEASE_BIT] = ~stable[emit_row][emit_col];
    push_evt[CW-1:0]      = CW'(evt_code(int'(emit_row), int'(emit_col), COLS));
  end

  key_evt_fifo #(
    .WIDTH (CW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_evt),
    .pop       (key_ready),
    .ovf_clr   (ovf_clr),
    .head      (key_evt),
    .valid     (key_valid),
    .count     (evt_count),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: press-only and press+release instances against a
// cycle-level behavioural model, plus directed scenarios with literal expectations.
module tb_keypad_scan_ctrl;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int SD    = 8;
  localparam int DEB   = 2;
  localparam int DEPTH = 4;
  localparam int NK    = ROWS * COLS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pressed = '0;
  logic        key_ready = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [3:0]  col0, col1, fila0, fila1;
  logic [4:0]  evt0, evt1;
  logic        val0, val1, ovf0, ovf1;
  logic [2:0]  cnt0, cnt1;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  // Physical keypads: a closed key connects its row to its driven column.
  always_comb begin
    fila0 = '0;
    fila1 = '0;
    for (int r = 0; r < ROWS; r++) begin
      fila0[r] = |(pressed[r*COLS +: COLS] & col0);
      fila1[r] = |(pressed[r*COLS +: COLS] & col1);
    end
  end

  keypad_scan_ctrl #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DEBOUNCE_SCANS(DEB),
                     .FIFO_DEPTH(DEPTH), .REPORT_RELEASE(0)) dut0 (
    .clk(clk), .rst(rst), .col(col0), .fila(fila0), .key_evt(evt0), .key_valid(val0),
    .key_ready(key_ready), .evt_count(cnt0), .overflow(ovf0), .ovf_clr(ovf_clr));

  keypad_scan_ctrl #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DEBOUNCE_SCANS(DEB),
                     .FIFO_DEPTH(DEPTH), .REPORT_RELEASE(1)) dut1 (
    .clk(clk), .rst(rst), .col(col1), .fila(fila1), .key_evt(evt1), .key_valid(val1),
    .key_ready(key_ready), .evt_count(cnt1), .overflow(ovf1), .ovf_clr(ovf_clr));

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: t = clock edges since reset; column and slot follow from t by arithmetic.
  int          t;
  logic [3:0]  h1, h2;
  bit          st [NK];
  int          dc [NK];
  int          due_t [$];
  logic [4:0]  due_e [$];
  logic [4:0]  fq [2][$];
  logic [4:0]  m_head [2];
  bit          m_ovf [2];

  function automatic bit has_due(input int when);
    for (int i = 0; i < due_t.size(); i++) if (due_t[i] == when) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin : model
    int pos, c, k, sz;
    logic [3:0] smp, fnow;
    bit have, ok, pop;
    logic [4:0] ev;
    if (rst) begin
      t = 0; h1 = '0; h2 = '0;
      for (int i = 0; i < NK; i++) begin st[i] = 1'b0; dc[i] = 0; end
      due_t.delete(); due_e.delete();
      for (int m = 0; m < 2; m++) begin fq[m].delete(); m_head[m] = '0; m_ovf[m] = 1'b0; end
    end else begin
      pos = t % SD;
      c   = (t / SD) % COLS;
      for (int r = 0; r < ROWS; r++) fnow[r] = pressed[r*COLS + c];
      smp = h2; h2 = h1; h1 = fnow;
      if (pos == SD - 1) begin
        for (int r = 0; r < ROWS; r++) begin
          k = r * COLS + c;
          if (smp[r] != st[k]) begin
            dc[k]++;
            if (dc[k] == DEB) begin
              st[k] = ~st[k]; dc[k] = 0;
              due_t.push_back(t + 1 + r);
              due_e.push_back({~st[k], 4'(k)});
            end
          end else dc[k] = 0;
        end
      end
      have = 1'b0; ev = '0;
      for (int i = 0; i < due_t.size(); i++) if (due_t[i] == t) begin have = 1'b1; ev = due_e[i]; end
      for (int i = due_t.size() - 1; i >= 0; i--)
        if (due_t[i] == t) begin due_t.delete(i); due_e.delete(i); end
      for (int m = 0; m < 2; m++) begin
        ok  = have && (m == 1 || ev[4] == 1'b0);
        sz  = fq[m].size();
        pop = key_ready && sz > 0;
        if (pop) void'(fq[m].pop_front());
        if (ok && (sz < DEPTH || pop)) fq[m].push_back(ev);
        if (ok && sz == DEPTH && !pop) m_ovf[m] = 1'b1;
        else if (ovf_clr) m_ovf[m] = 1'b0;
        if (fq[m].size() > 0) m_head[m] = fq[m][0];
      end
      t++;
    end
  end

  always @(negedge clk) begin : compare
    int ec;
    if (!rst) begin
      ec = 1 << ((t / SD) % COLS);
      check("col[0]",   col0, ec);
      check("col[1]",   col1, ec);
      check("evt[0]",   evt0, m_head[0]);
      check("evt[1]",   evt1, m_head[1]);
      check("valid[0]", val0, int'(fq[0].size() > 0));
      check("valid[1]", val1, int'(fq[1].size() > 0));
      check("count[0]", cnt0, fq[0].size());
      check("count[1]", cnt1, fq[1].size());
      check("ovf[0]",   ovf0, m_ovf[0]);
      check("ovf[1]",   ovf1, m_ovf[1]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int n);
    key_ready = 1'b1; tick(n); key_ready = 1'b0;
  endtask

  initial begin
    bit found;
    int k;
    // 1. reset
    tick(2); rst = 1'b0;
    tick(13);
    #2 rst = 1'b1;
    #1;
    check("t1 col async", col0, 4'b0001);
    check("t1 valid async", val0, 0);
    check("t1 count async", cnt0, 0);
    check("t1 ovf async", ovf0, 0);
    @(negedge clk) rst = 1'b0;
    tick(7);  check("t1 col at 7", col0, 4'b0001);
    tick(1);  check("t1 col at 8", col0, 4'b0010);
    tick(24); check("t1 col at 32", col0, 4'b0001);

    // 2/6. single press of key 9 (row 2, column 1), then release
    pressed[9] = 1'b1; tick(96);
    check("t2 evt", evt0, 5'h09); check("t2 valid", val0, 1); check("t2 count", cnt0, 1);
    check("t6 evt rel", evt1, 5'h09);
    pressed[9] = 1'b0; tick(96);
    check("t6 count norel", cnt0, 1);
    check("t6 count rel", cnt1, 2);
    drain(1);
    check("t2 valid after pop", val0, 0);
    check("t6 head rel", evt1, 5'h19);
    drain(1);
    check("t6 count rel empty", cnt1, 0);

    // 3. one-scan bounce
    pressed[9] = 1'b1; tick(32); pressed[9] = 1'b0; tick(96);
    check("t3 count", cnt0, 0);
    check("t3 count rel", cnt1, 0);

    // 4. rows 0 and 3 on column 2
    pressed[2] = 1'b1; pressed[14] = 1'b1; tick(96);
    check("t4 count", cnt0, 2); check("t4 first", evt0, 5'h02);
    drain(1);
    check("t4 second", evt0, 5'h0E);
    pressed = '0; tick(96); drain(6);
    check("t4 drained", cnt0, 0); check("t4 drained rel", cnt1, 0);

    // 5. overflow
    pressed[0] = 1'b1; tick(96);
    pressed[5] = 1'b1; tick(96);
    pressed[10] = 1'b1; tick(96);
    pressed[15] = 1'b1; tick(96);
    pressed[1] = 1'b1; tick(96);
    check("t5 count", cnt0, 4); check("t5 ovf", ovf0, 1); check("t5 head", evt0, 5'h00);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    check("t5 ovf clr", ovf0, 0);
    pressed[6] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (has_due(t)) found = 1'b1;
      else tick(1);
    end
    check("t5 push seen", found, 1);
    drain(1);
    check("t5 count pop+push", cnt0, 4); check("t5 ovf pop+push", ovf0, 0);
    check("t5 head pop+push", evt0, 5'h05);
    pressed = '0; drain(120);
    check("t5 drained", cnt0, 0); check("t5 drained rel", cnt1, 0);

    // random traffic, with a reset while keys are held
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        k = $urandom_range(0, NK - 1);
        pressed[k] = ~pressed[k];
      end
      key_ready = ($urandom_range(0, 3) == 0);
      ovf_clr   = ($urandom_range(0, 30) == 0);
      if (i == 2500) begin pressed[3] = 1'b1; rst = 1'b1; tick(2); rst = 1'b0; end
      tick(1);
    end
    key_ready = 1'b0; ovf_clr = 1'b0;
    tick(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
